// File: rtl/ti_c2h_event_packer.sv
// ti_c2h_event_packer: timestamps masked trigger pulses, buffers them in a
// FIFO and ships blocks of events as framed 64-bit AXI-stream packets
// (header, n events, trailer). Each completed block bumps block_number and
// can raise a level PCIe user IRQ request that stays up until acknowledged.
module ti_c2h_event_packer #(
  parameter  int NCH        = 4,
  parameter  int FIFO_DEPTH = 256,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic            CLKReg,
  input  logic            axi_aresetn,
  input  logic [NCH-1:0]  trig_in,
  input  logic            enable,
  input  logic [NCH-1:0]  chan_mask,
  input  logic [7:0]      block_level,
  input  logic            flush,
  input  logic            irq_en,
  output logic [63:0]     s_axis_c2h_tdata,
  output logic            s_axis_c2h_tvalid,
  input  logic            s_axis_c2h_tready,
  output logic            s_axis_c2h_tlast,
  output logic [7:0]      s_axis_c2h_tkeep,
  output logic            usr_irq_req,
  input  logic            usr_irq_ack,
  output logic [CW-1:0]   fifo_count,
  output logic [15:0]     overflow_cnt,
  output logic [31:0]     block_number
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_TRL} state_t;

  state_t          r_state, w_state_nxt;
  logic [47:0]     r_ts;
  logic [NCH-1:0]  w_hit;
  logic            r_evt_vld;
  logic [63:0]     r_evt;
  logic [63:0]     r_mem [FIFO_DEPTH];
  logic [CW-1:0]   r_wr_ptr, r_rd_ptr, w_count;
  logic            w_full, w_rd, w_wr_ok;
  logic [15:0]     r_ovf;
  logic [31:0]     r_blk;
  logic            r_flush_pend, r_irq;
  logic [7:0]      w_bl, w_n_nxt, r_n, r_left;
  logic            w_take;
  logic            r_tvalid, r_tlast;
  logic [63:0]     r_tdata;
  logic            w_load, w_hs;
  logic            w_ld_en, w_ld_last, w_trl_done;
  logic [63:0]     w_ld_data;

  assign w_hit   = trig_in & chan_mask;
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == CW'(FIFO_DEPTH));
  // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign w_wr_ok = r_evt_vld && (!w_full || w_rd);
  assign w_bl    = (block_level == 8'd0) ? 8'd1 : block_level;
  // Output register may take a new word when empty or when its word is being accepted.
  assign w_load  = !r_tvalid || s_axis_c2h_tready;
  assign w_hs    = r_tvalid && s_axis_c2h_tready;
  assign w_take  = (r_state == S_IDLE) &&
                   ((16'(w_count) >= 16'(w_bl)) || (r_flush_pend && (w_count != '0)));
  // Block length is min(bl, count): equals bl for a threshold start, the short size for a flush.
  assign w_n_nxt = (16'(w_count) < 16'(w_bl)) ? 8'(w_count) : w_bl;

  // Free-running timestamp and one-cycle capture register for the packed event.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLKReg or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_ts      <= '0;
      r_evt_vld <= 1'b0;
      r_evt     <= '0;
    end else begin
      r_ts      <= r_ts + 48'd1;
      r_evt_vld <= enable && (w_hit != '0);
      r_evt     <= {16'(w_hit), r_ts};
    end
  end

  // Event storage.
  // NOTE: the RAM array has no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge CLKReg) begin
    if (w_wr_ok) r_mem[r_wr_ptr[AW-1:0]] <= r_evt;
  end

  // FIFO pointers and saturating drop counter.
  always_ff @(posedge CLKReg or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_rd)    r_rd_ptr <= r_rd_ptr + CW'(1);
      if (r_evt_vld && !w_wr_ok && (r_ovf != 16'hFFFF)) r_ovf <= r_ovf + 16'd1;
    end
  end

  // Packer state register.
  always_ff @(posedge CLKReg or negedge axi_aresetn) begin
    if (!axi_aresetn) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Next state plus the word to load into the output register this cycle.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_ld_en     = 1'b0;
    w_ld_data   = '0;
    w_ld_last   = 1'b0;
    w_trl_done  = 1'b0;
    case (r_state)
      S_IDLE: if (w_take) w_state_nxt = S_HDR;
      S_HDR: if (w_load) begin
        w_ld_en     = 1'b1;
        w_ld_data   = {8'hB1, 8'h00, 16'(r_n), r_blk};
        w_state_nxt = S_DATA;
      end
      S_DATA: if (w_load) begin
        w_ld_en   = 1'b1;
        w_ld_data = r_mem[r_rd_ptr[AW-1:0]];
        w_rd      = 1'b1;
        if (r_left == 8'd1) w_state_nxt = S_TRL;
      end
      S_TRL: begin
        if (r_tvalid && r_tlast) begin
          // Trailer on the bus: the block counts only once it is accepted.
          if (s_axis_c2h_tready) begin
            w_trl_done  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_load) begin
          w_ld_en   = 1'b1;
          w_ld_data = {8'hB2, 24'h0, 32'(r_n) + 32'd2};
          w_ld_last = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Block bookkeeping: latched length, words left, pending flush, counters, IRQ.
  always_ff @(posedge CLKReg or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_n          <= '0;
      r_left       <= '0;
      r_flush_pend <= 1'b0;
      r_blk        <= '0;
      r_irq        <= 1'b0;
    end else begin
      if (w_take) begin
        r_n    <= w_n_nxt;
        r_left <= w_n_nxt;
      end else if (w_rd) begin
        r_left <= r_left - 8'd1;
      end
      // A flush into an idle, empty FIFO is dropped; otherwise it waits for the next start.
      r_flush_pend <= (r_flush_pend || (flush && !((r_state == S_IDLE) && (w_count == '0))))
                      && !w_take;
      if (w_trl_done) r_blk <= r_blk + 32'd1;
      if (w_trl_done && irq_en) r_irq <= 1'b1;
      else if (usr_irq_ack)     r_irq <= 1'b0;
    end
  end

  // Registered AXI-stream output; a held word changes only after acceptance.
  always_ff @(posedge CLKReg or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else if (w_ld_en) begin
      r_tvalid <= 1'b1;
      r_tlast  <= w_ld_last;
      r_tdata  <= w_ld_data;
    end else if (w_hs) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  assign s_axis_c2h_tdata  = r_tdata;
  assign s_axis_c2h_tvalid = r_tvalid;
  assign s_axis_c2h_tlast  = r_tlast;
  assign s_axis_c2h_tkeep  = 8'hFF;
  assign usr_irq_req       = r_irq;
  assign fifo_count        = w_count;
  assign overflow_cnt      = r_ovf;
  assign block_number      = r_blk;

endmodule

// File: tb/tb_ti_c2h_event_packer.sv
// Testbench for ti_c2h_event_packer: directed scenarios plus randomized
// traffic, checked against an event-queue model of the packet stream.
module tb_ti_c2h_event_packer;

  localparam int NCH   = 4;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NCH-1:0]  trig_in = '0;
  logic            enable = 1'b0;
  logic [NCH-1:0]  chan_mask = '1;
  logic [7:0]      block_level = 8'd1;
  logic            flush = 1'b0;
  logic            irq_en = 1'b1;
  logic            tready = 1'b0;
  logic            ack = 1'b0;
  logic [63:0]     tdata;
  logic            tvalid, tlast, irq;
  logic [7:0]      tkeep;
  logic [CW-1:0]   fifo_count;
  logic [15:0]     ovf;
  logic [31:0]     blknum;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [47:0] cyc;
  logic [64:0] got[$];
  logic [63:0] exp_ev[$];
  int          exp_blk = 0;
  int          exp_ovf = 0;
  bit          model_stall = 1'b0;

  ti_c2h_event_packer #(.NCH(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .CLKReg(clk), .axi_aresetn(rst_n), .trig_in(trig_in), .enable(enable),
    .chan_mask(chan_mask), .block_level(block_level), .flush(flush), .irq_en(irq_en),
    .s_axis_c2h_tdata(tdata), .s_axis_c2h_tvalid(tvalid), .s_axis_c2h_tready(tready),
    .s_axis_c2h_tlast(tlast), .s_axis_c2h_tkeep(tkeep), .usr_irq_req(irq),
    .usr_irq_ack(ack), .fifo_count(fifo_count), .overflow_cnt(ovf), .block_number(blknum)
  );

  always #5 clk = ~clk;

  // Cycle count since reset release: equals the timestamp a trigger driven now will carry.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 48'd1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Stream monitor: records accepted beats, checks stalled words stay put.
  logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [63:0] prev_d = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_tvalid", 65'(tvalid), 65'(1));
        check("hold_tdata", 65'(tdata), 65'(prev_d));
        check("hold_tlast", 65'(tlast), 65'(prev_l));
      end
      if (tvalid && tready) got.push_back({tlast, tdata});
      prev_v = tvalid; prev_r = tready; prev_d = tdata; prev_l = tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a trigger pattern for the coming edge and update the event model.
  task automatic drive(input logic [NCH-1:0] t);
    logic [NCH-1:0] hit;
    trig_in = t;
    hit = t & chan_mask;
    if (enable && (hit != '0)) begin
      if (model_stall && (exp_ev.size() >= DEPTH)) exp_ovf++;
      else exp_ev.push_back({16'(hit), cyc});
    end
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && got.size() < n; i++) tick();
    check(tag, 65'(got.size()), 65'(n));
  endtask

  // Consume received beats as packets: each block carries min(bl, queued) events.
  task automatic parse(input int bl);
    logic [64:0] w;
    int want_n;
    while (got.size() > 0) begin
      if (exp_ev.size() == 0) begin
        check("extra_beats", 65'(got.size()), 65'(0));
        got.delete();
        return;
      end
      want_n = (exp_ev.size() < bl) ? exp_ev.size() : bl;
      w = got.pop_front();
      check("hdr", w, {1'b0, 8'hB1, 8'h00, 16'(want_n), 32'(exp_blk)});
      for (int i = 0; i < want_n; i++) begin
        if (got.size() == 0) return;
        w = got.pop_front();
        check("event", w, {1'b0, exp_ev.pop_front()});
      end
      if (got.size() == 0) return;
      w = got.pop_front();
      check("trl", w, {1'b1, 8'hB2, 24'h0, 32'(want_n + 2)});
      exp_blk++;
    end
    check("block_number", 65'(blknum), 65'(exp_blk));
  endtask

  initial begin
    int bl, e, full, rem;
    bit found;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 65'(tvalid), 65'(0));
    check("rst_tdata", 65'(tdata), 65'(0));
    check("rst_tlast", 65'(tlast), 65'(0));
    check("rst_irq", 65'(irq), 65'(0));
    check("rst_ovf", 65'(ovf), 65'(0));
    check("rst_blk", 65'(blknum), 65'(0));
    check("rst_fifo", 65'(fifo_count), 65'(0));
    check("tkeep", 65'(tkeep), 65'(8'hFF));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic block: two events, bl=2
    enable = 1'b1; block_level = 8'd2; tready = 1'b1;
    repeat (8) tick();
    drive(4'b0001); tick(); trig_in = '0;
    check("lat_t1", 65'(fifo_count), 65'(0));
    tick();
    check("lat_t2", 65'(fifo_count), 65'(1));
    repeat (7) tick();
    drive(4'b0100); tick(); trig_in = '0;
    tick();
    check("thr_count", 65'(fifo_count), 65'(2));
    tick(); tick();
    check("hdr_tvalid", 65'(tvalid), 65'(1));
    check("hdr_word", 65'(tdata), 65'(64'hB100_0002_0000_0000));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = tvalid && tlast;
    end
    check("trl_seen", 65'(found), 65'(1));
    check("irq_before_trl", 65'(irq), 65'(0));
    tick();
    check("irq_after_trl", 65'(irq), 65'(1));
    wait_beats(4, 20, "basic_beats");
    parse(2);
    repeat (3) tick();
    check("irq_held", 65'(irq), 65'(1));
    ack = 1'b1; tick(); ack = 1'b0;
    check("irq_acked", 65'(irq), 65'(0));

    // Simultaneous and masked channels, block_level 0 acts as 1
    block_level = 8'd0; chan_mask = 4'b0011;
    drive(4'b1011); tick();
    drive(4'b1000); tick(); trig_in = '0;
    wait_beats(3, 30, "masked_beats");
    repeat (6) tick();
    check("masked_no_extra", 65'(got.size()), 65'(3));
    parse(1);
    enable = 1'b0;
    drive(4'b0011); tick(); trig_in = '0;
    repeat (4) tick();
    check("disabled_fifo", 65'(fifo_count), 65'(0));
    check("disabled_beats", 65'(got.size()), 65'(0));
    enable = 1'b1; chan_mask = '1;

    // Flush a short block, with backpressure in the data phase
    block_level = 8'd8;
    drive(4'b0001); tick(); trig_in = '0; repeat (3) tick();
    drive(4'b0010); tick(); trig_in = '0; repeat (3) tick();
    drive(4'b1000); tick(); trig_in = '0; repeat (4) tick();
    check("flush_fifo", 65'(fifo_count), 65'(3));
    check("flush_idle", 65'(tvalid), 65'(0));
    flush = 1'b1; tick(); flush = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (tvalid && !tlast && (tdata[63:56] == 8'h00)) found = 1'b1;
      else tick();
    end
    check("bp_data_seen", 65'(found), 65'(1));
    tready = 1'b0;
    repeat (5) tick();
    tready = 1'b1;
    wait_beats(5, 30, "flush_beats");
    parse(8);
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (10) tick();
    check("empty_flush_beats", 65'(got.size()), 65'(0));
    check("empty_flush_tvalid", 65'(tvalid), 65'(0));
    check("empty_flush_blk", 65'(blknum), 65'(exp_blk));

    // Flush during a block stays pending and yields a follow-up short block
    block_level = 8'd2; tready = 1'b0;
    drive(4'b0001); tick();
    drive(4'b0010); tick();
    drive(4'b0100); tick(); trig_in = '0;
    repeat (4) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    tready = 1'b1;
    wait_beats(7, 40, "pend_flush_beats");
    parse(2);

    // Overflow: 20 capture cycles into a 16-deep FIFO with nothing draining
    block_level = 8'd255; tready = 1'b0; model_stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(4'($urandom_range(1, 15)));
      tick();
    end
    trig_in = '0; model_stall = 1'b0;
    repeat (3) tick();
    check("ovf_fifo", 65'(fifo_count), 65'(DEPTH));
    check("ovf_cnt", 65'(ovf), 65'(exp_ovf));
    tready = 1'b1; block_level = 8'd16;
    wait_beats(18, 60, "ovf_beats");
    parse(16);

    // Randomized traffic with random backpressure, masks and enable
    for (int run = 0; run < 2; run++) begin
      bl = $urandom_range(1, 5);
      block_level = 8'(bl);
      for (int i = 0; i < 300; i++) begin
        tready    = ($urandom_range(0, 3) != 0);
        chan_mask = 4'($urandom);
        enable    = ($urandom_range(0, 9) != 0);
        drive(($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000);
        tick();
      end
      trig_in = '0; enable = 1'b1; chan_mask = '1; tready = 1'b1;
      repeat (3) tick();
      e = exp_ev.size(); full = e / bl; rem = e % bl;
      wait_beats(full * (bl + 2), 2000, "rand_blocks");
      flush = 1'b1; tick(); flush = 1'b0;
      wait_beats(full * (bl + 2) + ((rem != 0) ? rem + 2 : 0), 100, "rand_total");
      repeat (5) tick();
      check("rand_no_extra", 65'(got.size()), 65'(full * (bl + 2) + ((rem != 0) ? rem + 2 : 0)));
      check("rand_ovf", 65'(ovf), 65'(exp_ovf));
      parse(bl);
    end

    // IRQ: ack coinciding with a new trailer handshake leaves the request set
    ack = 1'b1; tick(); ack = 1'b0;
    check("irq_cleared", 65'(irq), 65'(0));
    block_level = 8'd1;
    drive(4'b0010); tick(); trig_in = '0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = tvalid && tlast;
    end
    check("irq_trl_seen", 65'(found), 65'(1));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("irq_set_wins", 65'(irq), 65'(1));
    wait_beats(3, 10, "irq_beats");
    parse(1);
    irq_en = 1'b0;
    ack = 1'b1; tick(); ack = 1'b0;
    drive(4'b0100); tick(); trig_in = '0;
    wait_beats(3, 20, "noirq_beats");
    repeat (2) tick();
    check("irq_disabled", 65'(irq), 65'(0));
    parse(1);
    irq_en = 1'b1;

    // Reset in the middle of the data phase
    block_level = 8'd4; tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(4'(1 << i)); tick();
    end
    trig_in = '0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (tvalid && !tlast && (tdata[63:56] == 8'h00)) found = 1'b1;
      else tick();
    end
    check("rst_data_seen", 65'(found), 65'(1));
    tready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 65'(tvalid), 65'(0));
    check("mid_rst_tlast", 65'(tlast), 65'(0));
    check("mid_rst_tdata", 65'(tdata), 65'(0));
    check("mid_rst_blk", 65'(blknum), 65'(0));
    check("mid_rst_fifo", 65'(fifo_count), 65'(0));
    check("mid_rst_ovf", 65'(ovf), 65'(0));
    @(negedge clk);
    rst_n = 1'b1;
    got.delete(); exp_ev.delete(); exp_blk = 0; exp_ovf = 0;
    tready = 1'b1; block_level = 8'd1;
    tick();
    repeat (3) tick();
    drive(4'b1001); tick(); trig_in = '0;
    wait_beats(3, 20, "post_rst_beats");
    parse(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
